// File: rtl/instr_sequencer.sv
// Instruction sequencer for the bit-serial PE array controller.
// Issues host-loaded instructions one at a time from a small synchronous
// memory, then waits for the datapath's done strobe before advancing.
// Opcodes are checked on decode, and a per-instruction watchdog bounds the wait.
module instr_sequencer #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 6,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    input  logic              run,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              ctrl_done,
    output logic [31:0]       instruction,
    output logic              start,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int              LEN_W       = ADDR_W + 1;
    localparam logic [5:0]      OP_HALT     = 6'd63;
    localparam logic [1:0]      ERR_NONE    = 2'd0;
    localparam logic [1:0]      ERR_ILLEGAL = 2'd1;
    localparam logic [1:0]      ERR_TIMEOUT = 2'd2;
    localparam logic [7:0]      WD_LIMIT    = 8'(TIMEOUT);
    localparam logic [7:0]      WD_MAX      = 8'hFF;
    localparam logic [LEN_W-1:0] FULL_LEN   = LEN_W'(IMEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       imem [IMEM_DEPTH];
    logic [LEN_W-1:0]  len_q;
    logic [7:0]        wd;
    logic [5:0]        opcode;
    logic              last_instr;

    // Opcodes the datapath understands; HALT is handled separately.
    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'd0, 6'd1, 6'd2, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10: op_legal = 1'b1;
            default:                                               op_legal = 1'b0;
        endcase
    endfunction

    assign opcode     = instruction[31:26];
    assign last_instr = ({1'b0, pc} == (len_q - LEN_W'(1)));

    // Host write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // Read port output register doubles as the instruction register, so a
    // new word appears entering DECODE and stays put through ISSUE and WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= '0;
        end else if (state_q == S_FETCH) begin
            instruction <= imem[pc];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ctrl_done is only looked at in WAIT, and wins a tie with the watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALTED;
                end else if (!op_legal(opcode)) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (ctrl_done) begin
                    state_d = last_instr ? S_HALTED : S_FETCH;
                end else if (wd == WD_LIMIT) begin
                    state_d = S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start  <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
            err    <= 1'b0;
        end else begin
            start  <= (state_d == S_ISSUE);
            busy   <= (state_d != S_IDLE) && (state_d != S_HALTED) && (state_d != S_ERROR);
            halted <= (state_d == S_HALTED);
            err    <= (state_d == S_ERROR);
        end
    end

    // Program counter, length latch, watchdog and error cause.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            len_q    <= '0;
            wd       <= '0;
            err_code <= ERR_NONE;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (run) begin
                        len_q    <= (prog_len == '0) ? FULL_LEN : prog_len;
                        pc       <= '0;
                        err_code <= ERR_NONE;
                    end
                end
                S_DECODE: begin
                    if ((opcode != OP_HALT) && !op_legal(opcode)) begin
                        err_code <= ERR_ILLEGAL;
                    end
                end
                S_ISSUE: wd <= '0;
                S_WAIT: begin
                    if (wd != WD_MAX) begin
                        wd <= wd + 8'd1;
                    end
                    if (ctrl_done) begin
                        if (!last_instr) begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end else if (wd == WD_LIMIT) begin
                        err_code <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: two instances (long and short watchdog) share
// one stimulus stream; a timeline model predicts start cycles, end cycle and
// final status for each instance.
module tb_instr_sequencer;
    localparam int AW      = 6;
    localparam int LW      = AW + 1;
    localparam int DEPTH   = 64;
    localparam int TMO_A   = 255;
    localparam int TMO_B   = 20;
    localparam int OBS_MAX = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          run;
    logic [AW:0]   prog_len;
    logic          ctrl_done;

    logic [31:0]   ins_o    [2];
    logic          start_o  [2];
    logic [AW-1:0] pc_o     [2];
    logic          busy_o   [2];
    logic          halted_o [2];
    logic          err_o    [2];
    logic [1:0]    code_o   [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] mem_m [DEPTH];
    int          dly   [DEPTH];
    int          ext   [DEPTH];
    int          legal_ops [9] = '{0, 1, 2, 5, 6, 7, 8, 9, 10};

    int          e_n    [2];
    int          e_cyc  [2][DEPTH];
    logic [31:0] e_ins  [2][DEPTH];
    int          e_term [2];
    logic        e_halt [2];
    logic [1:0]  e_code [2];
    int          e_pc   [2];

    int          obs_n    [2] = '{0, 0};
    int          obs_cyc  [2][OBS_MAX];
    logic [31:0] obs_ins  [2][OBS_MAX];
    int          fall_cyc [2] = '{-1, -1};
    logic        bprev    [2] = '{1'b0, 1'b0};

    instr_sequencer #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TMO_A)) dut_a (
        .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .run(run), .prog_len(prog_len), .ctrl_done(ctrl_done),
        .instruction(ins_o[0]), .start(start_o[0]), .pc(pc_o[0]), .busy(busy_o[0]),
        .halted(halted_o[0]), .err(err_o[0]), .err_code(code_o[0])
    );

    instr_sequencer #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TMO_B)) dut_b (
        .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .run(run), .prog_len(prog_len), .ctrl_done(ctrl_done),
        .instruction(ins_o[1]), .start(start_o[1]), .pc(pc_o[1]), .busy(busy_o[1]),
        .halted(halted_o[1]), .err(err_o[1]), .err_code(code_o[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every start pulse and the cycle busy last fell, per instance.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (start_o[m] && obs_n[m] < OBS_MAX) begin
                obs_cyc[m][obs_n[m]] <= cyc;
                obs_ins[m][obs_n[m]] <= ins_o[m];
                obs_n[m]             <= obs_n[m] + 1;
            end
            if (bprev[m] && !busy_o[m]) fall_cyc[m] <= cyc;
            bprev[m] <= busy_o[m];
        end
    end

    initial begin
        #2000000;
        $display("FAIL sim_time_limit: got no finish, expected finish before limit");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input int op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Timeline model: run sampled at the end of cycle r; fetch, decode and
    // issue each take a cycle; done arrives dly[k] cycles after start k; the
    // watchdog tolerates done up to tmo+1 cycles after start.
    task automatic model(input int m, input int tmo, input int r, input int len);
        int f, s, op;
        f = r + 1;
        e_n[m] = 0; e_halt[m] = 1'b0; e_code[m] = 2'd0; e_pc[m] = 0; e_term[m] = -1;
        for (int k = 0; k < len; k++) begin
            op = int'(mem_m[k][31:26]);
            e_pc[m] = k;
            if (op == 63) begin
                e_halt[m] = 1'b1; e_term[m] = f + 2; return;
            end
            if (!is_legal(op)) begin
                e_code[m] = 2'd1; e_term[m] = f + 2; return;
            end
            s = f + 2;
            e_cyc[m][e_n[m]] = s;
            e_ins[m][e_n[m]] = mem_m[k];
            e_n[m]++;
            if (dly[k] > tmo + 1) begin
                e_code[m] = 2'd2; e_term[m] = s + tmo + 2; return;
            end
            if (k == len - 1) begin
                e_halt[m] = 1'b1; e_term[m] = s + dly[k] + 1; return;
            end
            f = s + dly[k] + 1;
        end
    endtask

    task automatic load(input int a, input logic [31:0] w);
        @(posedge clk); #1;
        imem_we = 1'b1; imem_waddr = AW'(a); imem_wdata = w;
        mem_m[a] = w;
    endtask

    task automatic chk_reset_vals(input string nm);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s.%0d.instruction", nm, m), ins_o[m], 32'h0);
            chk($sformatf("%s.%0d.start", nm, m), 32'(start_o[m]), 32'h0);
            chk($sformatf("%s.%0d.pc", nm, m), 32'(pc_o[m]), 32'h0);
            chk($sformatf("%s.%0d.busy", nm, m), 32'(busy_o[m]), 32'h0);
            chk($sformatf("%s.%0d.halted", nm, m), 32'(halted_o[m]), 32'h0);
            chk($sformatf("%s.%0d.err", nm, m), 32'(err_o[m]), 32'h0);
            chk($sformatf("%s.%0d.err_code", nm, m), 32'(code_o[m]), 32'h0);
        end
    endtask

    // Run one program: drive run, done pulses (with optional spurious
    // extensions), an optional second run while busy and an optional
    // same-cycle write to the word being fetched; then compare against the model.
    task automatic scenario(input string nm, input int len_field, input bit probe,
                            input int rf_addr, input logic [31:0] rf_word);
        int r, len, endc, rf_cyc;
        int base [2];
        bit do_probe;
        len = (len_field == 0) ? DEPTH : len_field;
        @(posedge clk); #1;
        r = cyc;
        model(0, TMO_A, r, len);
        model(1, TMO_B, r, len);
        endc     = ((e_term[0] > e_term[1]) ? e_term[0] : e_term[1]) + 2;
        do_probe = probe && (e_term[0] > r + 5) && (e_term[1] > r + 5);
        rf_cyc   = (rf_addr >= 0 && rf_addr < e_n[0]) ? e_cyc[0][rf_addr] - 2 : -1;
        base[0]  = obs_n[0];
        base[1]  = obs_n[1];
        prog_len = LW'(len_field);
        for (int c = r; c <= endc; c++) begin
            if (c != r) begin
                @(posedge clk); #1;
            end
            run       = (c == r) || (do_probe && c == r + 5);
            ctrl_done = 1'b0;
            for (int k = 0; k < e_n[0]; k++) begin
                if (c >= e_cyc[0][k] + dly[k] && c <= e_cyc[0][k] + dly[k] + ext[k]) ctrl_done = 1'b1;
            end
            imem_we    = (c == rf_cyc);
            imem_waddr = AW'((rf_addr < 0) ? 0 : rf_addr);
            imem_wdata = rf_word;
        end
        run = 1'b0; ctrl_done = 1'b0; imem_we = 1'b0;
        @(negedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s.%0d.nstart", nm, m), obs_n[m] - base[m], e_n[m]);
            for (int k = 0; k < e_n[m]; k++) begin
                if (base[m] + k < obs_n[m]) begin
                    chk($sformatf("%s.%0d.start_cyc%0d", nm, m, k), obs_cyc[m][base[m] + k], e_cyc[m][k]);
                    chk($sformatf("%s.%0d.start_ins%0d", nm, m, k), obs_ins[m][base[m] + k], e_ins[m][k]);
                end
            end
            chk($sformatf("%s.%0d.end_cyc", nm, m), fall_cyc[m], e_term[m]);
            chk($sformatf("%s.%0d.halted", nm, m), 32'(halted_o[m]), 32'(e_halt[m]));
            chk($sformatf("%s.%0d.err", nm, m), 32'(err_o[m]), 32'(e_code[m] != 2'd0));
            chk($sformatf("%s.%0d.err_code", nm, m), 32'(code_o[m]), 32'(e_code[m]));
            chk($sformatf("%s.%0d.pc", nm, m), 32'(pc_o[m]), e_pc[m]);
            chk($sformatf("%s.%0d.busy", nm, m), 32'(busy_o[m]), 32'h0);
            chk($sformatf("%s.%0d.start_idle", nm, m), 32'(start_o[m]), 32'h0);
        end
        if (rf_cyc >= 0) mem_m[rf_addr] = rf_word;
    endtask

    initial begin
        int len, op;
        reset = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        run = 1'b0; prog_len = '0; ctrl_done = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            dly[k] = 1; ext[k] = 0; mem_m[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        reset = 1'b0;

        // One instruction then HALT; done after 65 cycles also trips the short watchdog.
        load(0, 32'h0400_0000); load(1, 32'hFC00_0000);
        dly[0] = 65;
        scenario("single", 2, 1'b0, -1, 32'h0);

        // Program ends on length.
        for (int k = 0; k < 3; k++) begin
            load(k, 32'h1400_0000 | 32'(k)); dly[k] = 10;
        end
        scenario("lenend", 3, 1'b0, -1, 32'h0);

        // Illegal opcode in word 1, then a run that clears the error.
        load(0, 32'h0800_0011); load(1, 32'h0C00_0000); load(2, 32'h0400_0000);
        dly[0] = 5;
        scenario("illegal", 3, 1'b0, -1, 32'h0);
        load(1, 32'h1800_0022);
        dly[1] = 4; dly[2] = 6;
        scenario("recover", 3, 1'b1, -1, 32'h0);

        // Done exactly on the watchdog limit, with done held into FETCH/DECODE.
        load(0, 32'h2000_0001); load(1, 32'h2400_0002);
        dly[0] = TMO_B + 1; ext[0] = 2; dly[1] = 3; ext[1] = 1;
        scenario("tie", 2, 1'b0, -1, 32'h0);
        ext[0] = 0; ext[1] = 0;

        // Write to the word being fetched returns the old word; next run sees the new one.
        load(0, 32'h0400_0001); load(1, 32'h1800_0002); load(2, 32'h2400_0003);
        dly[0] = 2; dly[1] = 2; dly[2] = 2;
        scenario("rdfirst", 3, 1'b0, 1, 32'h2800_00AA);
        scenario("rdnew", 3, 1'b0, -1, 32'h0);

        // prog_len = 0 runs the whole memory and stops at the last word.
        for (int k = 0; k < DEPTH; k++) begin
            load(k, {6'(legal_ops[k % 9]), 26'(k)});
            dly[k] = int'($urandom_range(1, 3));
        end
        scenario("full", 0, 1'b0, -1, 32'h0);

        // Asynchronous reset in the middle of WAIT, then rerun without reloading.
        imem_we = 1'b0;
        dly[0] = 40;
        @(posedge clk); #1;
        prog_len = LW'(2); run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (8) @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        chk_reset_vals("midwait");
        #2;
        reset = 1'b0;
        dly[0] = 4; dly[1] = 4;
        scenario("rerun", 2, 1'b0, -1, 32'h0);

        // Random programs.
        for (int i = 0; i < 24; i++) begin
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) begin
                case ($urandom_range(0, 19))
                    16, 17:  op = 63;
                    18:      op = int'($urandom_range(3, 4));
                    19:      op = int'($urandom_range(11, 62));
                    default: op = legal_ops[$urandom_range(0, 8)];
                endcase
                load(k, {6'(op), 26'($urandom)});
                case ($urandom_range(0, 9))
                    0:       dly[k] = int'($urandom_range(18, 30));
                    1:       dly[k] = TMO_B + 1;
                    default: dly[k] = int'($urandom_range(1, 8));
                endcase
                ext[k] = int'($urandom_range(0, 2));
            end
            scenario($sformatf("rand%0d", i), len, 1'($urandom_range(0, 1)), -1, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
